// File: rtl/emit_ctrl_mc.sv
// emit_ctrl_mc: per-job unit emitter. A job latches a channel and a unit
// count, waits for the dispense path to become ready, then requests one unit
// at a time on the latched channel. Each unit must be acknowledged within
// TIMEOUT cycles or the controller parks in a fault state until aborted.
module emit_ctrl_mc #(
  parameter int CH_W    = 2,
  parameter int CNT_W   = 8,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   RESET,
  input  logic                   load,
  input  logic [CH_W-1:0]        ch_sel,
  input  logic [CNT_W-1:0]       amount,
  input  logic                   out_ctrl,
  input  logic                   unit_ack,
  input  logic                   abort,
  output logic [(1<<CH_W)-1:0]   emit,
  output logic                   busy,
  output logic                   ld_ack,
  output logic [CNT_W-1:0]       remaining,
  output logic                   done,
  output logic                   aborted,
  output logic                   fault
);

  localparam int N_CH = 1 << CH_W;

  // Last legal value of the per-unit wait counter before declaring a fault.
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE_U   = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    WAIT  = 3'd2,
    COUNT = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  rem_q;
  logic [CH_W-1:0]   ch_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic              ld_ack_q;
  logic              done_q;
  logic              aborted_q;

  // Job sequencing: state, latched job parameters, timeout counter and the
  // one-cycle status pulses all advance together on the clock edge.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      ch_q      <= '0;
      to_cnt_q  <= '0;
      ld_ack_q  <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      // Pulses default low; each branch raises at most one of them.
      ld_ack_q  <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Only IDLE samples load, so a busy job never sees its
          // parameters overwritten.
          if (load) begin
            rem_q    <= amount;
            ch_q     <= ch_sel;
            ld_ack_q <= 1'b1;
            state_q  <= INIT;
          end
        end
        INIT: begin
          if (abort) begin
            rem_q     <= '0;
            aborted_q <= 1'b1;
            state_q   <= IDLE;
          end else if (out_ctrl) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (abort) begin
            rem_q     <= '0;
            aborted_q <= 1'b1;
            state_q   <= IDLE;
          end else if (rem_q == '0) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            to_cnt_q <= '0;
            state_q  <= COUNT;
          end
        end
        COUNT: begin
          // Abort wins over a coincident acknowledge; that unit is dropped.
          if (abort) begin
            rem_q     <= '0;
            aborted_q <= 1'b1;
            state_q   <= IDLE;
          end else if (unit_ack) begin
            if (rem_q != '0) begin
              rem_q <= rem_q - ONE_U;
            end
            state_q <= WAIT;
          end else if (to_cnt_q == TO_LAST) begin
            state_q <= ERR;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        ERR: begin
          // Fault is sticky: only abort (or reset) releases it.
          if (abort) begin
            rem_q     <= '0;
            aborted_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Unit request decoded from the registered state: one-hot on the latched
  // channel only while a unit is outstanding.
  always_comb begin
    emit = '0;
    if (state_q == COUNT) begin
      for (int i = 0; i < N_CH; i++) begin
        emit[i] = (ch_q == CH_W'(i));
      end
    end
  end

  // Status views of the registered state.
  always_comb begin
    busy      = (state_q != IDLE);
    fault     = (state_q == ERR);
    remaining = rem_q;
    ld_ack    = ld_ack_q;
    done      = done_q;
    aborted   = aborted_q;
  end

endmodule

// File: tb/tb_emit_ctrl_mc.sv
// Bench for emit_ctrl_mc: directed job scenarios plus randomized traffic,
// all cross-checked every cycle against a job-level behavioural model.
module tb_emit_ctrl_mc;

  localparam int CH_W    = 2;
  localparam int CNT_W   = 8;
  localparam int TO_W    = 8;
  localparam int TIMEOUT = 16;
  localparam int N_CH    = 1 << CH_W;

  logic              clk = 1'b0;
  logic              RESET;
  logic              load;
  logic [CH_W-1:0]   ch_sel;
  logic [CNT_W-1:0]  amount;
  logic              out_ctrl;
  logic              unit_ack;
  logic              abort;
  logic [N_CH-1:0]   emit;
  logic              busy;
  logic              ld_ack;
  logic [CNT_W-1:0]  remaining;
  logic              done;
  logic              aborted;
  logic              fault;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  emit_ctrl_mc #(
    .CH_W(CH_W), .CNT_W(CNT_W), .TO_W(TO_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .RESET(RESET), .load(load), .ch_sel(ch_sel), .amount(amount),
    .out_ctrl(out_ctrl), .unit_ack(unit_ack), .abort(abort),
    .emit(emit), .busy(busy), .ld_ack(ld_ack), .remaining(remaining),
    .done(done), .aborted(aborted), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Job-level model: a job exists, has (or has not) seen the path ready,
  // may have one unit outstanding for some number of cycles, or is faulted.
  bit m_job = 0, m_ready = 0, m_unit = 0, m_fault = 0;
  int m_age = 0, m_rem = 0, m_ch = 0;
  bit m_ldack = 0, m_done = 0, m_abt = 0;

  initial begin
    forever begin
      @(posedge clk or posedge RESET);
      if (RESET) begin
        m_job = 0; m_ready = 0; m_unit = 0; m_fault = 0;
        m_age = 0; m_rem = 0; m_ch = 0;
        m_ldack = 0; m_done = 0; m_abt = 0;
      end else begin
        m_ldack = 0; m_done = 0; m_abt = 0;
        if (!m_job) begin
          if (load) begin
            m_job = 1; m_ready = 0; m_unit = 0; m_fault = 0;
            m_rem = int'(amount); m_ch = int'(ch_sel); m_ldack = 1;
          end
        end else if (abort) begin
          m_job = 0; m_ready = 0; m_unit = 0; m_fault = 0;
          m_rem = 0; m_abt = 1;
        end else if (m_fault) begin
          // waits for abort
        end else if (!m_ready) begin
          if (out_ctrl) m_ready = 1;
        end else if (!m_unit) begin
          if (m_rem == 0) begin
            m_job = 0; m_ready = 0; m_done = 1;
          end else begin
            m_unit = 1; m_age = 0;
          end
        end else begin
          m_age++;
          if (unit_ack) begin
            m_rem--; m_unit = 0;
          end else if (m_age == TIMEOUT) begin
            m_unit = 0; m_fault = 1;
          end
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("emit", 32'(emit), m_unit ? (32'd1 << m_ch) : 32'd0);
        chk("busy", 32'(busy), 32'(m_job));
        chk("fault", 32'(fault), 32'(m_fault));
        chk("remaining", 32'(remaining), 32'(m_rem));
        chk("ld_ack", 32'(ld_ack), 32'(m_ldack));
        chk("done", 32'(done), 32'(m_done));
        chk("aborted", 32'(aborted), 32'(m_abt));
        chk("done_and_aborted", 32'(done & aborted), 32'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load = 0; ch_sel = '0; amount = '0; out_ctrl = 0; unit_ack = 0; abort = 0;
  endtask

  task automatic wait_emit(input int bound);
    for (int k = 0; k < bound; k++) begin
      if (emit != '0) break;
      step();
    end
    chk("wait_emit", 32'(emit != '0), 32'd1);
  endtask

  int rises, dones, ecnt;
  bit prev;
  int ack_pct;

  initial begin
    idle_inputs();
    RESET = 1;
    cmp_en = 1;
    step(); step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_emit", 32'(emit), 32'd0);
    chk("rst_remaining", 32'(remaining), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    RESET = 0;
    step();

    // Three units on channel 2, acknowledged while emit is up.
    load = 1; amount = 8'd3; ch_sel = 2'd2; out_ctrl = 1;
    step();
    load = 0;
    chk("r021_ld_ack", 32'(ld_ack), 32'd1);
    rises = 0; dones = 0; prev = 0;
    for (int k = 0; k < 40 && dones == 0; k++) begin
      step();
      if (emit != '0 && !prev) begin
        rises++;
        chk("r021_emit", 32'(emit), 32'b0100);
        chk("r021_rem", 32'(remaining), 32'(4 - rises));
      end
      prev = (emit != '0);
      unit_ack = (emit != '0);
      if (done) dones++;
    end
    unit_ack = 0;
    chk("r021_rises", 32'(rises), 32'd3);
    chk("r021_dones", 32'(dones), 32'd1);
    chk("r021_busy", 32'(busy), 32'd0);
    chk("r021_rem_end", 32'(remaining), 32'd0);
    step();

    // Zero-length job: ld_ack, then done within 3 cycles, no emit.
    load = 1; amount = 8'd0; ch_sel = 2'd1; out_ctrl = 1;
    step();
    load = 0;
    chk("r022_ld_ack", 32'(ld_ack), 32'd1);
    dones = 0; ecnt = 0;
    for (int k = 0; k < 3 && dones == 0; k++) begin
      step();
      if (emit != '0) ecnt++;
      if (done) dones++;
    end
    chk("r022_done", 32'(dones), 32'd1);
    chk("r022_emit_cnt", 32'(ecnt), 32'd0);
    step();

    // No acknowledge: exactly TIMEOUT cycles of emit, then fault.
    load = 1; amount = 8'd2; ch_sel = 2'd1; out_ctrl = 1;
    step();
    load = 0;
    ecnt = 0;
    for (int k = 0; k < 60; k++) begin
      if (fault) break;
      if (emit == 4'b0010) ecnt++;
      step();
    end
    chk("r023_emit_cycles", 32'(ecnt), 32'd16);
    chk("r023_fault", 32'(fault), 32'd1);
    chk("r023_emit_off", 32'(emit), 32'd0);
    chk("r023_busy", 32'(busy), 32'd1);
    abort = 1;
    step();
    abort = 0;
    chk("r023_fault_clr", 32'(fault), 32'd0);
    chk("r023_aborted", 32'(aborted), 32'd1);
    chk("r023_busy_clr", 32'(busy), 32'd0);
    step();

    // Abort and acknowledge together: unit not counted, remaining cleared.
    load = 1; amount = 8'd5; ch_sel = 2'd3; out_ctrl = 1;
    step();
    load = 0;
    wait_emit(10);
    chk("r024_rem5", 32'(remaining), 32'd5);
    abort = 1; unit_ack = 1;
    step();
    abort = 0; unit_ack = 0;
    chk("r024_rem0", 32'(remaining), 32'd0);
    chk("r024_aborted", 32'(aborted), 32'd1);
    chk("r024_no_done", 32'(done), 32'd0);
    chk("r024_busy", 32'(busy), 32'd0);
    step();

    // Load while busy is ignored.
    load = 1; amount = 8'd4; ch_sel = 2'd0; out_ctrl = 0;
    step();
    chk("r025_ld_ack", 32'(ld_ack), 32'd1);
    amount = 8'd9; ch_sel = 2'd3;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("r025_no_ld_ack", 32'(ld_ack), 32'd0);
      chk("r025_rem", 32'(remaining), 32'd4);
    end
    load = 0; out_ctrl = 1;
    wait_emit(10);
    chk("r025_emit_ch", 32'(emit), 32'b0001);
    abort = 1;
    step();
    abort = 0;
    chk("r025_aborted", 32'(aborted), 32'd1);
    step();

    // Asynchronous reset mid-unit, then a fresh one-unit job.
    load = 1; amount = 8'd3; ch_sel = 2'd2; out_ctrl = 1;
    step();
    load = 0;
    wait_emit(10);
    #2;
    RESET = 1;
    #1;
    chk("r026_emit", 32'(emit), 32'd0);
    chk("r026_busy", 32'(busy), 32'd0);
    chk("r026_rem", 32'(remaining), 32'd0);
    step();
    RESET = 0;
    load = 1; amount = 8'd1; ch_sel = 2'd0; out_ctrl = 1;
    step();
    load = 0;
    chk("r026_ld_ack", 32'(ld_ack), 32'd1);
    dones = 0;
    for (int k = 0; k < 20 && dones == 0; k++) begin
      step();
      unit_ack = (emit != '0);
      if (done) dones++;
    end
    unit_ack = 0;
    chk("r026_done", 32'(dones), 32'd1);
    step();

    // Randomized traffic; acknowledge rate alternates so timeouts also occur.
    for (int i = 0; i < 1500; i++) begin
      ack_pct = ((i / 100) % 3 == 0) ? 3 : 60;
      load     = ($urandom_range(0, 99) < 30);
      amount   = CNT_W'($urandom_range(0, 4));
      ch_sel   = CH_W'($urandom_range(0, N_CH - 1));
      out_ctrl = ($urandom_range(0, 99) < 80);
      unit_ack = ($urandom_range(0, 99) < ack_pct);
      abort    = ($urandom_range(0, 99) < 2);
      step();
    end
    idle_inputs();
    abort = 1;
    step();
    abort = 0;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/emit_ctrl_mc.md
EMIT_CTRL_MC -- requirements
Module: emit_ctrl_mc

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  CH_W, 2, channel-select width; channel count N_CH = 2**CH_W.
  CNT_W, 8, width of the unit amount and remaining counter.
  TO_W, 8, width of the acknowledge-timeout counter.
  TIMEOUT, 16, cycles allowed per unit without acknowledge; legal range 1..2**TO_W.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  single clock, rising edge.
  RESET  in  1  asynchronous, active-high reset.
  load  in  1  start request; sampled only in IDLE.
  ch_sel  in  CH_W  target channel, latched with load.
  amount  in  CNT_W  units to emit, latched with load.
  out_ctrl  in  1  dispense path ready.
  unit_ack  in  1  downstream acknowledge of one emitted unit.
  abort  in  1  cancel the current job or clear a fault.
  emit  out  N_CH  one-hot unit request on the latched channel.
  busy  out  1  high whenever state is not IDLE.
  ld_ack  out  1  one-cycle pulse confirming load accepted.
  remaining  out  CNT_W  units still to emit.
  done  out  1  one-cycle pulse when a job completes normally.
  aborted  out  1  one-cycle pulse when a job or fault is cancelled.
  fault  out  1  high while in ERR.

Function
REQ-003 The FSM SHALL have states IDLE, INIT, WAIT, COUNT and ERR, with a registered state and all registers updated on the rising edge of clk.
REQ-004 IDLE with load=1: latch rem<=amount and ch_q<=ch_sel, go to INIT, and pulse ld_ack (registered) in the next cycle only.
REQ-005 load SHALL be ignored in every state except IDLE, and latched values SHALL be unaffected by it.
REQ-006 INIT: go to WAIT when out_ctrl=1; otherwise stay in INIT.
REQ-007 WAIT with rem==0: go to IDLE and pulse done for one cycle; WAIT with rem!=0: go to COUNT and clear to_cnt to 0.
REQ-008 COUNT: emit[ch_q]=1 and all other emit bits SHALL be 0; emit SHALL be 0 in every other state (Moore output).
REQ-009 COUNT with unit_ack=1: rem<=rem-1, go to WAIT; rem SHALL never decrement below 0.
REQ-010 COUNT with unit_ack=0 and to_cnt==TIMEOUT-1: go to ERR; otherwise to_cnt<=to_cnt+1. emit SHALL therefore be high for exactly TIMEOUT cycles before a fault.
REQ-011 unit_ack SHALL be ignored outside COUNT.
REQ-012 abort=1 in INIT, WAIT or COUNT: go to IDLE, set rem<=0, pulse aborted; abort SHALL take priority over unit_ack in the same cycle, and that unit SHALL NOT be counted.
REQ-013 ERR: fault=1, emit=0, busy=1; leave ERR only on abort=1 (to IDLE, rem<=0, aborted pulse) or on reset.
REQ-014 abort in IDLE SHALL have no effect and SHALL produce no aborted pulse.
REQ-015 remaining SHALL equal rem at all times, and busy SHALL be derived combinationally from state.
REQ-016 amount=0 SHALL complete IDLE->INIT->WAIT->IDLE with a done pulse and no emit activity.
REQ-017 done and aborted SHALL never be asserted in the same cycle.

Reset
REQ-018 RESET=1 SHALL asynchronously force state=IDLE, rem=0, ch_q=0, to_cnt=0, and ld_ack=done=aborted=0, without waiting for a clock edge.
REQ-019 During reset, outputs SHALL be emit=0, busy=0, fault=0 and remaining=0.
REQ-020 The first rising edge after RESET deasserts SHALL evaluate load normally.

Verification (CH_W=2, CNT_W=8, TIMEOUT=16)
REQ-021 load, amount=3, ch_sel=2, out_ctrl=1, unit_ack one cycle after each emit rise -> emit=4'b0100 three times, remaining 3->2->1->0, one done pulse, then busy=0.
REQ-022 load, amount=0 -> ld_ack, then done within 3 cycles; emit stays 0 throughout.
REQ-023 load, amount=2, ch_sel=1, unit_ack never asserted -> emit=4'b0010 for exactly 16 cycles, then fault=1 and emit=0; abort -> fault=0, aborted pulse, busy=0.
REQ-024 In COUNT with remaining=5, abort and unit_ack asserted together -> remaining=0, aborted pulse, no done.
REQ-025 load while busy, with different ch_sel and amount -> no ld_ack, and latched channel and remaining are unchanged.
REQ-026 RESET asserted mid-COUNT between clock edges -> emit, busy and remaining drop to 0 immediately; after release, a new load of amount=1 completes normally.
